// File: rtl/vga_timing_pkg.sv
// Shared XGA (1024x768 @ 60 Hz) timing constants for the timing generator and draw modules.
package vga_timing_pkg;

  localparam int CNT_W = 12;

  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;

  localparam int H_TOTAL = XGA_H_ACTIVE + XGA_H_FP + XGA_H_SYNC + XGA_H_BP;
  localparam int V_TOTAL = XGA_V_ACTIVE + XGA_V_FP + XGA_V_SYNC + XGA_V_BP;

endpackage

// File: rtl/vga_axis_cnt.sv
// Wrapping axis counter: counts 0..TOTAL-1 while enabled; tc_o flags the last position.
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = H_TOTAL,
  parameter int W     = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] count_d_o,
  output logic         tc_o
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // The next value is exported so the parent can register decodes in step with the count.
  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign count_d_o = count_d;
  assign tc_o      = (count_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator with registered, zero-skew sync/blank/frame_start outputs.
// Optional macro VGA_TIMING_FRAME_CNT_EN adds a 16-bit wrapping frame counter output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = XGA_H_ACTIVE,
  parameter int H_FP     = XGA_H_FP,
  parameter int H_SYNC   = XGA_H_SYNC,
  parameter int H_BP     = XGA_H_BP,
  parameter int V_ACTIVE = XGA_V_ACTIVE,
  parameter int V_FP     = XGA_V_FP,
  parameter int V_SYNC   = XGA_V_SYNC,
  parameter int V_BP     = XGA_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] hcount_out,
  output logic             hsync_out,
  output logic             hblnk_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             vsync_out,
  output logic             vblnk_out,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_BLANK_START = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_START  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_BLANK_START = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_START  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hCount, hCountD, vCount, vCountD;
  logic             hTc, vTc;

  logic hsync_q, hblnk_q, vsync_q, vblnk_q, frame_start_q;
  logic frame_start_d;

  vga_axis_cnt #(.TOTAL(H_TOT), .W(CNT_W)) u_hcnt (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .count_o   (hCount),
    .count_d_o (hCountD),
    .tc_o      (hTc)
  );

  vga_axis_cnt #(.TOTAL(V_TOT), .W(CNT_W)) u_vcnt (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en && hTc),
    .count_o   (vCount),
    .count_d_o (vCountD),
    .tc_o      (vTc)
  );

  assign frame_start_d = en && hTc && vTc;

  // Decodes use the counters' next values so they land on the same edge as the counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q       <= 1'b0;
      hblnk_q       <= 1'b0;
      vsync_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
      if (en) begin
        hblnk_q <= (hCountD >= H_BLANK_START);
        hsync_q <= (hCountD >= H_SYNC_START) && (hCountD < H_SYNC_END);
        vblnk_q <= (vCountD >= V_BLANK_START);
        vsync_q <= (vCountD >= V_SYNC_START) && (vCountD < V_SYNC_END);
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (frame_start_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign hcount_out = hCount;
  assign vcount_out = vCount;
  assign hsync_out  = hsync_q;
  assign hblnk_out  = hblnk_q;
  assign vsync_out  = vsync_q;
  assign vblnk_out  = vblnk_q;
  assign frame_start = frame_start_q;

endmodule
